// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button / switch conditioner.
// Per channel: two-flop synchroniser, stable-count debounce filter,
// registered one-cycle press/release strobes and an optional
// hold-to-repeat strobe generator.
// Optional feature macro: BTN_REPEAT_EN (defined -> repeat FSM present,
// undefined -> o_repeat tied low and the REPEAT_* parameters ignored).
module button_conditioner #(
  parameter int unsigned NUM_CH          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic [NUM_CH-1:0] i_noisy,
  output logic [NUM_CH-1:0] o_clean,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_repeat
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PERIOD
  } rpt_state_t;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic            r_s1;
    logic            r_s2;
    logic            r_clean;
    logic            r_press;
    logic            r_release;
    logic [DB_W-1:0] r_cnt;
    logic            w_accept;
    logic            w_rise;
    logic            w_fall;

    // Acceptance happens on the edge where the mismatch streak completes.
    assign w_accept = (r_s2 != r_clean) && (r_cnt == DB_LAST);
    assign w_rise   = w_accept &  r_s2;
    assign w_fall   = w_accept & ~r_s2;

    // Two-flop synchroniser for the raw asynchronous input.
    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= i_noisy[c];
        r_s2 <= r_s1;
      end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_cnt     <= '0;
        r_clean   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (r_s2 == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_clean <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end

    assign o_clean[c]   = r_clean;
    assign o_press[c]   = r_press;
    assign o_release[c] = r_release;

`ifdef BTN_REPEAT_EN
    rpt_state_t       r_state;
    logic [RPT_W-1:0] r_rcnt;
    logic             r_repeat;

    // Hold-to-repeat FSM; it keys off the acceptance edge rather than the
    // registered strobe so the first repeat lands exactly REPEAT_DELAY
    // edges after the press strobe edge, and release always wins.
    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_state  <= ST_IDLE;
        r_rcnt   <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if (w_fall) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_state <= ST_DELAY;
                r_rcnt  <= '0;
              end
            end
            ST_DELAY: begin
              if (r_rcnt == RD_LAST) begin
                r_repeat <= 1'b1;
                r_rcnt   <= '0;
                r_state  <= ST_PERIOD;
              end else begin
                r_rcnt <= r_rcnt + RPT_W'(1);
              end
            end
            ST_PERIOD: begin
              if (r_rcnt == RP_LAST) begin
                r_repeat <= 1'b1;
                r_rcnt   <= '0;
              end else begin
                r_rcnt <= r_rcnt + RPT_W'(1);
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign o_repeat[c] = r_repeat;
`else
    assign o_repeat[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (NUM_CH=4, DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=6). A reference model predicts each
// cycle's outputs from the input history; a monitor compares after each edge.
module tb_button_conditioner;

  localparam int NCH = 4;
  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;
`ifdef BTN_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic           clk;
  logic           resetn;
  logic [NCH-1:0] noisy;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] press;
  logic [NCH-1:0] rel;
  logic [NCH-1:0] rpt;

  button_conditioner #(
    .NUM_CH         (NCH),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_noisy  (noisy),
    .o_clean  (clean),
    .o_press  (press),
    .o_release(rel),
    .o_repeat (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] p;
    logic [NCH-1:0] r;
    logic [NCH-1:0] t;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Reference model: a level is accepted once the last DB synchronised
  // samples (inputs seen 2..DB+1 edges ago) all disagree with the current
  // accepted level. Repeats fire at press+RD+k*RP while the level is held.
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_clean;
  bit             held[NCH];
  int             age[NCH];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (!resetn) begin
      hist = {};
      for (int i = 0; i < DB + 2; i++) hist.push_back('0);
      m_clean = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        held[ch] = 1'b0;
        age[ch]  = 0;
      end
    end else begin
      hist.push_front(noisy);
      void'(hist.pop_back());
      for (int ch = 0; ch < NCH; ch++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int i = 2; i <= DB + 1; i++)
          if (hist[i][ch] == m_clean[ch]) all_diff = 1'b0;
        if (all_diff) begin
          if (!m_clean[ch]) begin
            e.p[ch]  = 1'b1;
            held[ch] = 1'b1;
            age[ch]  = 0;
          end else begin
            e.r[ch]  = 1'b1;
            held[ch] = 1'b0;
          end
          m_clean[ch] = ~m_clean[ch];
        end else if (held[ch]) begin
          age[ch]++;
          if (RPT_ON && age[ch] >= RD && ((age[ch] - RD) % RP) == 0) e.t[ch] = 1'b1;
        end
      end
    end
    e.c = m_clean;
    sb.push_back(e);
  end

  // Monitor: pops one prediction per edge and compares away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = sb.pop_front();
        check("clean",   clean, e.c);
        check("press",   press, e.p);
        check("release", rel,   e.r);
        check("repeat",  rpt,   e.t);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset must clear every output before the next edge.
  task automatic reset_pulse(input int n);
    resetn = 1'b0;
    #1;
    check("async_rst_clean",   clean, '0);
    check("async_rst_press",   press, '0);
    check("async_rst_release", rel,   '0);
    check("async_rst_repeat",  rpt,   '0);
    cyc(n);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    noisy  = 4'hF;
    cyc(5);
    resetn = 1'b1;
    cyc(15);
    noisy = '0;
    cyc(15);

    // clean press on ch0
    noisy[0] = 1'b1;
    cyc(15);

    // 7-cycle glitch on ch1, then chatter ending in a stable high
    noisy[1] = 1'b1;
    cyc(7);
    noisy[1] = 1'b0;
    cyc(15);
    repeat (5) begin
      noisy[1] = 1'b1;
      cyc(3);
      noisy[1] = 1'b0;
      cyc(2);
    end
    noisy[1] = 1'b1;
    cyc(15);

    // simultaneous release ch2 / press ch3
    noisy[2] = 1'b1;
    cyc(15);
    noisy[2] = 1'b0;
    noisy[3] = 1'b1;
    cyc(15);

    // hold ch0; release lands where a repeat would otherwise fall
    noisy[0] = 1'b0;
    cyc(15);
    noisy[0] = 1'b1;
    cyc(62);
    noisy[0] = 1'b0;
    cyc(20);

    // reset in the middle of a debounce count
    noisy[0] = 1'b1;
    cyc(4);
    reset_pulse(3);
    cyc(15);

    // reset during the repeat period phase
    noisy = '0;
    cyc(15);
    noisy[0] = 1'b1;
    cyc(39);
    reset_pulse(3);
    noisy = '0;
    cyc(15);

    // randomised traffic: choppy then long-hold phases, rare resets
    for (int ph = 0; ph < 4; ph++) begin
      int p_tog;
      p_tog = (ph % 2 == 0) ? 8 : 1;
      for (int n = 0; n < 1500; n++) begin
        for (int ch = 0; ch < NCH; ch++)
          if ($urandom_range(0, 99) < p_tog) noisy[ch] = ~noisy[ch];
        if ($urandom_range(0, 599) == 0) reset_pulse(2);
        else cyc(1);
      end
    end

    cyc(15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
